// File: rtl/cache_sim_pkg.sv
// Shared definitions for the cache simulation slice: default bus widths,
// the responder state encoding and the per-level timing constants.
package cache_sim_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;

    // Nominal access times (cycles) for each level of the hierarchy.
    localparam int L1_TIME  = 1;
    localparam int L2_TIME  = 5;
    localparam int MEM_TIME = 100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } mem_state_t;

endpackage

// File: rtl/main_mem_responder_if.sv
// Refill request / response stream bundle between the L2 miss path
// (master) and the backing-store responder (slave).
interface main_mem_responder_if #(
    parameter int ADDR_W = cache_sim_pkg::ADDR_W,
    parameter int DATA_W = cache_sim_pkg::DATA_W
);

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_last;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last
    );

endinterface

// File: rtl/mem_latency_timer.sv
// Loadable down-counter that paces the memory latency. done is high when
// the counter will reach zero on the next enabled edge, so the owner can
// change state on that same edge.
module mem_latency_timer #(
    parameter int MAX_COUNT = 100,
    localparam int CNT_W    = $clog2(MAX_COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [CNT_W-1:0] count_reg;

    // Load takes priority; otherwise count down while enabled, stopping at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == CNT_W'(1));

endmodule

// File: rtl/main_mem_responder.sv
// Backing-store responder for L2 refills. Accepts one request, waits
// MEM_LATENCY cycles, then streams the line critical-word-first with
// wrap inside the line. Data is {DATA_TAG, beat word address}.
// Optional build macro: MAIN_MEM_STATS_EN adds saturating request and
// stall counters (stat_reqs, stat_stall).
module main_mem_responder #(
    parameter int ADDR_W      = cache_sim_pkg::ADDR_W,
    parameter int DATA_W      = cache_sim_pkg::DATA_W,
    parameter int LINE_WORDS  = 4,
    parameter int MEM_LATENCY = cache_sim_pkg::MEM_TIME,
    parameter logic [DATA_W-ADDR_W-1:0] DATA_TAG = 21'h0A5A5
) (
    input  logic                 clk,
    input  logic                 rst,
    main_mem_responder_if.slave  bus,
    output logic                 busy
`ifdef MAIN_MEM_STATS_EN
    ,
    output logic [31:0]          stat_reqs,
    output logic [31:0]          stat_stall
`endif
);

    import cache_sim_pkg::*;

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int LAT_W = $clog2(MEM_LATENCY + 1);

    mem_state_t              state_reg, state_next;
    logic [ADDR_W-OFF_W-1:0] line_reg;
    logic [OFF_W-1:0]        crit_reg;
    logic [OFF_W-1:0]        beat_reg;
    logic                    timer_load;
    logic                    timer_en;
    logic                    timer_done;
    logic                    fire;
    logic                    last_beat;
    logic [ADDR_W-1:0]       beat_addr;

    // A beat completes only while streaming and the consumer takes it.
    assign fire      = (state_reg == BURST) && bus.rsp_ready;
    assign last_beat = (beat_reg == OFF_W'(LINE_WORDS - 1));
    // Offset adds modulo the line size, so the line is never left.
    assign beat_addr = {line_reg, crit_reg + beat_reg};

    mem_latency_timer #(
        .MAX_COUNT (MEM_LATENCY)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (LAT_W'(MEM_LATENCY - 1)),
        .en       (timer_en),
        .done     (timer_done)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and all stream outputs; outputs are zero outside BURST.
    always_comb begin
        state_next    = state_reg;
        timer_load    = 1'b0;
        timer_en      = 1'b0;
        busy          = 1'b1;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_last  = 1'b0;
        bus.rsp_addr  = '0;
        bus.rsp_data  = '0;
        case (state_reg)
            IDLE: begin
                busy          = 1'b0;
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    timer_load = 1'b1;
                    // A one-cycle latency has no wait phase at all.
                    state_next = (MEM_LATENCY == 1) ? BURST : WAIT;
                end
            end
            WAIT: begin
                timer_en = 1'b1;
                if (timer_done) begin
                    state_next = BURST;
                end
            end
            BURST: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_last  = last_beat;
                bus.rsp_addr  = beat_addr;
                bus.rsp_data  = {DATA_TAG, beat_addr};
                if (bus.rsp_ready && last_beat) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture the line and critical word on acceptance; step the beat on each handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_reg <= '0;
            crit_reg <= '0;
            beat_reg <= '0;
        end else if (timer_load) begin
            line_reg <= bus.req_addr[ADDR_W-1:OFF_W];
            crit_reg <= bus.req_addr[OFF_W-1:0];
            beat_reg <= '0;
        end else if (fire) begin
            beat_reg <= beat_reg + 1'b1;
        end
    end

`ifdef MAIN_MEM_STATS_EN
    logic [31:0] reqs_reg;
    logic [31:0] stall_reg;

    // Saturating counters of accepted requests and back-pressured beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reqs_reg  <= '0;
            stall_reg <= '0;
        end else begin
            if (timer_load && (reqs_reg != '1)) begin
                reqs_reg <= reqs_reg + 32'd1;
            end
            if ((state_reg == BURST) && !bus.rsp_ready && (stall_reg != '1)) begin
                stall_reg <= stall_reg + 32'd1;
            end
        end
    end

    assign stat_reqs  = reqs_reg;
    assign stat_stall = stall_reg;
`endif

endmodule

// File: tb/tb_main_mem_responder.sv
// Self-checking bench for main_mem_responder: table-driven line bursts,
// hand-written corner sequences (stall, held request, reset in WAIT/BURST,
// unit latency) and randomized requests against an arithmetic line model.
module tb_main_mem_responder;

    localparam int AW  = 11;
    localparam int DW  = 32;
    localparam int LW  = 4;
    localparam int LAT = 4;
    localparam logic [20:0] TAG = 21'h0A5A5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    main_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) a_if ();
    main_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) b_if ();
    logic a_busy, b_busy;
`ifdef MAIN_MEM_STATS_EN
    logic [31:0] a_reqs, a_stall, b_reqs, b_stall;
`endif

    main_mem_responder #(
        .ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW), .MEM_LATENCY(LAT), .DATA_TAG(TAG)
    ) dut_a (
        .clk  (clk),
        .rst  (rst),
        .bus  (a_if),
        .busy (a_busy)
`ifdef MAIN_MEM_STATS_EN
        ,
        .stat_reqs  (a_reqs),
        .stat_stall (a_stall)
`endif
    );

    main_mem_responder #(
        .ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW), .MEM_LATENCY(1), .DATA_TAG(TAG)
    ) dut_b (
        .clk  (clk),
        .rst  (rst),
        .bus  (b_if),
        .busy (b_busy)
`ifdef MAIN_MEM_STATS_EN
        ,
        .stat_reqs  (b_reqs),
        .stat_stall (b_stall)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [10:0]       addr;
        logic [3:0][10:0]  exp_a;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Line model: base of the aligned line plus the wrapped word offset.
    function automatic logic [10:0] model_addr(input logic [10:0] req, input int i);
        int base;
        int crit;
        base = (int'(req) / LW) * LW;
        crit = int'(req) % LW;
        return 11'(base + (crit + i) % LW);
    endfunction

    // Issue one request on dut_a (called #1 after an edge, DUT idle) and check the whole burst.
    task automatic run_req(input logic [10:0] addr, input logic [3:0][10:0] exp_a,
                           input int stall_beat, input int stall_n,
                           input bit hold_next, input logic [10:0] next_addr);
        int j;
        logic [31:0] ed;
        check("req_ready_idle", 32'(a_if.req_ready), 32'd1);
        a_if.req_valid = 1'b1;
        a_if.req_addr  = addr;
        @(posedge clk); #1;
        if (hold_next) a_if.req_addr = next_addr;
        else           a_if.req_valid = 1'b0;
        check("busy_after_accept", 32'(a_busy), 32'd1);
        j = 0;
        while (!a_if.rsp_valid && j < 400) begin
            check("req_ready_wait", 32'(a_if.req_ready), 32'd0);
            @(posedge clk); #1;
            j++;
        end
        check("latency", 32'(j), 32'(LAT - 1));
        for (int i = 0; i < LW; i++) begin
            ed = {TAG, exp_a[i]};
            if (i == stall_beat) begin
                a_if.rsp_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    @(posedge clk); #1;
                    check("stall_valid", 32'(a_if.rsp_valid), 32'd1);
                    check("stall_addr", 32'(a_if.rsp_addr), 32'(exp_a[i]));
                    check("stall_data", a_if.rsp_data, ed);
                end
                a_if.rsp_ready = 1'b1;
            end
            check("beat_valid", 32'(a_if.rsp_valid), 32'd1);
            check("beat_addr", 32'(a_if.rsp_addr), 32'(exp_a[i]));
            check("beat_data", a_if.rsp_data, ed);
            check("beat_last", 32'(a_if.rsp_last), 32'(i == LW - 1));
            check("req_ready_burst", 32'(a_if.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        check("end_rsp_valid", 32'(a_if.rsp_valid), 32'd0);
        check("end_req_ready", 32'(a_if.req_ready), 32'd1);
        check("end_busy", 32'(a_busy), 32'd0);
        $display("txn addr=%03h lat=%0d stall_beat=%0d stall_n=%0d hold=%0d", addr, j + 1,
                 stall_beat, stall_n, hold_next);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        logic [3:0][10:0] e;
        logic [10:0] ra;
        int j;
`ifdef MAIN_MEM_STATS_EN
        logic [31:0] s0, r0;
`endif

        vecs[0] = '{11'h123, {11'h122, 11'h121, 11'h120, 11'h123}};
        vecs[1] = '{11'h7FE, {11'h7FD, 11'h7FC, 11'h7FF, 11'h7FE}};
        vecs[2] = '{11'h000, {11'h003, 11'h002, 11'h001, 11'h000}};
        vecs[3] = '{11'h7FF, {11'h7FE, 11'h7FD, 11'h7FC, 11'h7FF}};
        vecs[4] = '{11'h2B9, {11'h2B8, 11'h2BB, 11'h2BA, 11'h2B9}};

        a_if.req_valid = 1'b0; a_if.req_addr = '0; a_if.rsp_ready = 1'b1;
        b_if.req_valid = 1'b0; b_if.req_addr = '0; b_if.rsp_ready = 1'b1;

        // Reset state
        #2;
        check("rst_req_ready", 32'(a_if.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(a_if.rsp_valid), 32'd0);
        check("rst_rsp_last", 32'(a_if.rsp_last), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_rsp_data", a_if.rsp_data, 32'd0);
        check("rst_rsp_addr", 32'(a_if.rsp_addr), 32'd0);
`ifdef MAIN_MEM_STATS_EN
        check("rst_stat_reqs", a_reqs, 32'd0);
        check("rst_stat_stall", a_stall, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven bursts, including both wrap cases at the top line
        for (int v = 0; v < 5; v++) begin
            run_req(vecs[v].addr, vecs[v].exp_a, LW, 0, 1'b0, 11'h000);
        end

        // Back-pressure on beat 2 for three cycles
`ifdef MAIN_MEM_STATS_EN
        s0 = a_stall; r0 = a_reqs;
`endif
        run_req(11'h123, vecs[0].exp_a, 2, 3, 1'b0, 11'h000);
`ifdef MAIN_MEM_STATS_EN
        check("stat_stall_delta", a_stall - s0, 32'd3);
        check("stat_reqs_delta", a_reqs - r0, 32'd1);
`endif

        // Request held through a burst is taken right after the last handshake
        for (int i = 0; i < LW; i++) e[i] = model_addr(11'h0A7, i);
        run_req(11'h0A7, e, LW, 0, 1'b1, 11'h040);
        run_req(11'h040, {11'h043, 11'h042, 11'h041, 11'h040}, LW, 0, 1'b0, 11'h000);

        // Reset during WAIT
        a_if.req_valid = 1'b1; a_if.req_addr = 11'h333;
        @(posedge clk); #1;
        a_if.req_valid = 1'b0;
        @(posedge clk); #1;
        check("wait_busy_before_rst", 32'(a_busy), 32'd1);
        rst = 1'b1; #1;
        check("rst_wait_rsp_valid", 32'(a_if.rsp_valid), 32'd0);
        check("rst_wait_req_ready", 32'(a_if.req_ready), 32'd1);
        check("rst_wait_busy", 32'(a_busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            @(posedge clk); #1;
            check("post_rst_wait_quiet", 32'(a_if.rsp_valid), 32'd0);
        end

        // Reset mid-BURST, after one beat has been taken
        a_if.req_valid = 1'b1; a_if.req_addr = 11'h2C5;
        @(posedge clk); #1;
        a_if.req_valid = 1'b0;
        j = 0;
        while (!a_if.rsp_valid && j < 400) begin
            @(posedge clk); #1;
            j++;
        end
        check("pre_rst_latency", 32'(j), 32'(LAT - 1));
        @(posedge clk); #1;
        check("mid_burst_addr", 32'(a_if.rsp_addr), 32'h2C6);
        rst = 1'b1; #1;
        check("rst_burst_rsp_valid", 32'(a_if.rsp_valid), 32'd0);
        check("rst_burst_req_ready", 32'(a_if.req_ready), 32'd1);
        check("rst_burst_busy", 32'(a_busy), 32'd0);
        check("rst_burst_rsp_last", 32'(a_if.rsp_last), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_burst_quiet", 32'(a_if.rsp_valid), 32'd0);
        run_req(11'h010, {11'h013, 11'h012, 11'h011, 11'h010}, LW, 0, 1'b0, 11'h000);

        // Randomized requests and stalls against the line model
        for (int n = 0; n < 16; n++) begin
            ra = 11'($urandom_range(0, 2047));
            for (int i = 0; i < LW; i++) e[i] = model_addr(ra, i);
            run_req(ra, e, int'($urandom_range(0, LW)), int'($urandom_range(1, 3)), 1'b0, 11'h000);
        end

        // Unit latency: first beat already valid after the accepting edge
        b_if.req_valid = 1'b1; b_if.req_addr = 11'h2A1;
        @(posedge clk); #1;
        b_if.req_valid = 1'b0;
        for (int i = 0; i < LW; i++) begin
            check("lat1_valid", 32'(b_if.rsp_valid), 32'd1);
            check("lat1_addr", 32'(b_if.rsp_addr), 32'(model_addr(11'h2A1, i)));
            check("lat1_data", b_if.rsp_data, {TAG, model_addr(11'h2A1, i)});
            check("lat1_last", 32'(b_if.rsp_last), 32'(i == LW - 1));
            @(posedge clk); #1;
        end
        check("lat1_end_req_ready", 32'(b_if.req_ready), 32'd1);
        check("lat1_end_busy", 32'(b_busy), 32'd0);
        $display("txn lat1 addr=2a1 done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/main_mem_responder.md
Name: main_mem_responder

Overview:
Backing-store responder at the far end of the L2 miss path. It accepts one line-refill read request at a time and waits a fixed memory latency. It then returns the line one word per beat, critical word first, over a valid/ready stream. Read data is a deterministic function of the address, so benches can check every beat without a memory image.

Parameters:
ADDR_W, 11, word address width (2048-word space).
DATA_W, 32, data word width.
LINE_WORDS, 4, words per refill line; power of two, >=2.
MEM_LATENCY, 100, cycles from request acceptance to first response beat; >=1.
DATA_TAG, 21'h0A5A5, upper DATA_W-ADDR_W bits of every returned word.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  1  refill request present.
req_ready  out  1  responder can accept a request.
req_addr  in  ADDR_W  requested (critical) word address.
rsp_valid  out  1  response beat valid.
rsp_ready  in  1  consumer accepts beat.
rsp_data  out  DATA_W  {DATA_TAG, beat word address}.
rsp_addr  out  ADDR_W  word address of current beat.
rsp_last  out  1  final beat of line.
busy  out  1  request in flight (not IDLE).

Behaviour:
- Reset (async assert, sync release):
  - FSM to IDLE; latency counter and beat counter to 0.
  - req_ready=1, rsp_valid=0, rsp_last=0, busy=0, rsp_data=0, rsp_addr=0.
  - In-flight burst is dropped; no partial beats after reset deasserts.
- FSM states:
  - IDLE: req_ready=1. req_valid&&req_ready at edge k captures req_addr, loads counter with MEM_LATENCY-1, goes to WAIT.
  - WAIT: req_ready=0, counter decrements. On counter==0 go to BURST. rsp_valid is first high in the cycle after edge k+MEM_LATENCY-1, i.e. first sampled at edge k+MEM_LATENCY.
  - BURST: rsp_valid=1. Beat i address is base | ((crit+i) mod LINE_WORDS).
    - base = req_addr with low log2(LINE_WORDS) bits cleared; crit = those low bits.
    - Beat advances only on rsp_valid&&rsp_ready. rsp_data/rsp_addr/rsp_last hold stable while rsp_ready=0.
    - rsp_last=1 on beat LINE_WORDS-1. Its handshake returns the FSM to IDLE; req_ready is high the following cycle.
- Request handling:
  - One outstanding request; no queueing.
  - req_valid while busy is ignored (req_ready=0); the requester must hold it.
  - Requests are never accepted in the same cycle the last beat completes.
- Arithmetic: word wrap is within the line only. Beat counter width is log2(LINE_WORDS); it wraps naturally. Address never crosses the line boundary, including the line at 0x7FC-0x7FF.
- rsp_ready low for any number of cycles stalls indefinitely with no data loss.

Optional Feature:
MAIN_MEM_STATS_EN
- Defined: adds outputs stat_reqs[31:0] (+1 per accepted request) and stat_stall[31:0] (+1 per cycle rsp_valid&&!rsp_ready). Both reset to 0 and saturate at 32'hFFFFFFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package cache_sim_pkg holds:
  - ADDR_W=11, DATA_W=32.
  - State encoding: IDLE=2'd0, WAIT=2'd1, BURST=2'd2.
  - Shared timing constants L1_TIME=1, L2_TIME=5, MEM_TIME=100.
- One sub-module, mem_latency_timer: loadable down-counter with a done flag, width $clog2(MEM_LATENCY+1).

Test Plan:
- MEM_LATENCY=4, LINE_WORDS=4, request 0x123 at edge k, rsp_ready=1 -> beats at edges k+4..k+7 with addr 0x123,0x120,0x121,0x122; rsp_data={DATA_TAG,addr}; rsp_last only on 0x122; req_ready high at k+8.
- Request 0x7FE -> addresses 0x7FE,0x7FF,0x7FC,0x7FD; no overflow past 0x7FF.
- Hold rsp_ready=0 for 3 cycles on beat 2 -> rsp_data/rsp_addr stable, burst resumes intact. With MAIN_MEM_STATS_EN, stat_stall=3 and stat_reqs=1.
- req_valid held high throughout a burst with new addr 0x040 -> not accepted until IDLE. Accepted the cycle after rsp_last handshake; second burst starts at 0x040.
- Assert rst in WAIT and again mid-BURST -> rsp_valid drops immediately, req_ready=1, busy=0. The next request 0x010 completes normally with full latency.
- MEM_LATENCY=1 -> first beat sampled at edge k+1; four beats back-to-back.
